// File: rtl/timebase_counter_if.sv
// rtl/timebase_counter_if.sv - snapshot handshake bundle for timebase_counter
interface timebase_counter_if #(
    parameter int unsigned SEC_W = 32,
    parameter int unsigned SUB_W = 10
);
    logic             snap_req;
    logic             snap_ready;
    logic             snap_valid;
    logic             snap_drop;
    logic [SEC_W-1:0] snap_sec;
    logic [SUB_W-1:0] snap_msec;
    logic [SUB_W-1:0] snap_usec;

    // Reader side: requests snapshots and accepts them.
    modport master (
        output snap_req, snap_ready,
        input  snap_valid, snap_drop, snap_sec, snap_msec, snap_usec
    );

    // Timebase side: captures and holds snapshots.
    modport slave (
        input  snap_req, snap_ready,
        output snap_valid, snap_drop, snap_sec, snap_msec, snap_usec
    );
endinterface

// File: rtl/timebase_counter.sv
// rtl/timebase_counter.sv - sec/msec/usec wall-clock timebase with snapshot port; optional alarm under TIMEBASE_ALARM_EN
module timebase_counter #(
    parameter int unsigned CLK_FREQ_HZ = 200_000_000,
    parameter int unsigned SEC_W       = 32,
    parameter int unsigned SUB_W       = 10
) (
    input  logic             clk_200mhz,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [SEC_W-1:0] load_sec,
    input  logic [SUB_W-1:0] load_msec,
    input  logic [SUB_W-1:0] load_usec,
    output logic [SEC_W-1:0] sec,
    output logic [SUB_W-1:0] msec,
    output logic [SUB_W-1:0] usec,
    output logic             us_tick,
    output logic             ms_tick,
    output logic             s_tick,
    output logic             sec_wrap,
`ifdef TIMEBASE_ALARM_EN
    input  logic             alarm_arm,
    input  logic [SEC_W-1:0] alarm_sec,
    input  logic [SUB_W-1:0] alarm_msec,
    input  logic             alarm_clr,
    output logic             alarm_irq,
`endif
    timebase_counter_if.slave snap
);
    localparam int unsigned TICKS_PER_US = CLK_FREQ_HZ / 1_000_000;
    localparam int unsigned PRE_W        = $clog2(TICKS_PER_US) + 1;
    localparam logic [PRE_W-1:0] PRE_TC  = PRE_W'(TICKS_PER_US - 1);
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(999);

    logic [PRE_W-1:0] presc;
    logic             count_step;
    logic             us_wrap;
    logic             ms_wrap;
    logic [SEC_W-1:0] nxt_sec;
    logic [SUB_W-1:0] nxt_msec;
    logic [SUB_W-1:0] nxt_usec;
    logic             snap_take;

    // Next time value if the prescaler wraps this cycle; load suppresses counting.
    always_comb begin
        count_step = en && !load && (presc == PRE_TC);
        us_wrap    = (usec == SUB_MAX);
        ms_wrap    = (msec == SUB_MAX);
        nxt_usec   = us_wrap ? '0 : usec + SUB_W'(1);
        nxt_msec   = msec;
        nxt_sec    = sec;
        if (us_wrap) begin
            nxt_msec = ms_wrap ? '0 : msec + SUB_W'(1);
            if (ms_wrap) begin
                nxt_sec = sec + SEC_W'(1);
            end
        end
    end

    // Prescaler, time counters and their one-cycle tick strobes.
    always_ff @(posedge clk_200mhz or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            sec      <= '0;
            msec     <= '0;
            usec     <= '0;
            us_tick  <= 1'b0;
            ms_tick  <= 1'b0;
            s_tick   <= 1'b0;
            sec_wrap <= 1'b0;
        end else begin
            us_tick  <= 1'b0;
            ms_tick  <= 1'b0;
            s_tick   <= 1'b0;
            sec_wrap <= 1'b0;
            if (load) begin
                presc <= '0;
                sec   <= load_sec;
                msec  <= (load_msec > SUB_MAX) ? SUB_MAX : load_msec;
                usec  <= (load_usec > SUB_MAX) ? SUB_MAX : load_usec;
            end else if (en) begin
                if (count_step) begin
                    presc    <= '0;
                    sec      <= nxt_sec;
                    msec     <= nxt_msec;
                    usec     <= nxt_usec;
                    us_tick  <= 1'b1;
                    ms_tick  <= us_wrap;
                    s_tick   <= us_wrap && ms_wrap;
                    sec_wrap <= us_wrap && ms_wrap && (sec == '1);
                end else begin
                    presc <= presc + PRE_W'(1);
                end
            end
        end
    end

    // A request is taken when nothing is held or the held snapshot is leaving this cycle.
    assign snap_take = snap.snap_req && (!snap.snap_valid || snap.snap_ready);

    // Snapshot holding register with valid/ready handshake and drop indication.
    always_ff @(posedge clk_200mhz or posedge reset) begin
        if (reset) begin
            snap.snap_valid <= 1'b0;
            snap.snap_drop  <= 1'b0;
            snap.snap_sec   <= '0;
            snap.snap_msec  <= '0;
            snap.snap_usec  <= '0;
        end else begin
            snap.snap_drop <= snap.snap_req && snap.snap_valid && !snap.snap_ready;
            if (snap_take) begin
                snap.snap_valid <= 1'b1;
                snap.snap_sec   <= sec;
                snap.snap_msec  <= msec;
                snap.snap_usec  <= usec;
            end else if (snap.snap_valid && snap.snap_ready) begin
                snap.snap_valid <= 1'b0;
            end
        end
    end

`ifdef TIMEBASE_ALARM_EN
    logic             armed;
    logic [SEC_W-1:0] tgt_sec;
    logic [SUB_W-1:0] tgt_msec;

    // Alarm fires on the edge counting reaches the target; clear beats fire, arm replaces target.
    always_ff @(posedge clk_200mhz or posedge reset) begin
        if (reset) begin
            armed     <= 1'b0;
            tgt_sec   <= '0;
            tgt_msec  <= '0;
            alarm_irq <= 1'b0;
        end else begin
            if (count_step && armed && (nxt_sec == tgt_sec) &&
                (nxt_msec == tgt_msec) && (nxt_usec == '0)) begin
                armed     <= 1'b0;
                alarm_irq <= 1'b1;
            end
            if (alarm_clr) begin
                alarm_irq <= 1'b0;
            end
            if (alarm_arm) begin
                armed    <= 1'b1;
                tgt_sec  <= alarm_sec;
                tgt_msec <= alarm_msec;
            end
        end
    end
`endif
endmodule

// File: tb/tb_timebase_counter.sv
// tb/tb_timebase_counter.sv - directed self-checking bench for timebase_counter
module tb_timebase_counter;
    localparam int unsigned CLK_FREQ_HZ = 4_000_000;
    localparam int unsigned SEC_W       = 4;
    localparam int unsigned SUB_W       = 10;

    typedef struct packed {
        logic [SEC_W-1:0] s;
        logic [SUB_W-1:0] m;
        logic [SUB_W-1:0] u;
    } snap_t;

    logic             clk_200mhz = 1'b0;
    logic             reset;
    logic             en;
    logic             load;
    logic [SEC_W-1:0] load_sec;
    logic [SUB_W-1:0] load_msec;
    logic [SUB_W-1:0] load_usec;
    logic [SEC_W-1:0] sec;
    logic [SUB_W-1:0] msec;
    logic [SUB_W-1:0] usec;
    logic             us_tick;
    logic             ms_tick;
    logic             s_tick;
    logic             sec_wrap;
`ifdef TIMEBASE_ALARM_EN
    logic             alarm_arm;
    logic [SEC_W-1:0] alarm_sec;
    logic [SUB_W-1:0] alarm_msec;
    logic             alarm_clr;
    logic             alarm_irq;
`endif

    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];
    snap_t exp_s;

    timebase_counter_if #(.SEC_W(SEC_W), .SUB_W(SUB_W)) sif ();

    timebase_counter #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .SEC_W(SEC_W),
        .SUB_W(SUB_W)
    ) dut (
        .clk_200mhz(clk_200mhz),
        .reset(reset),
        .en(en),
        .load(load),
        .load_sec(load_sec),
        .load_msec(load_msec),
        .load_usec(load_usec),
        .sec(sec),
        .msec(msec),
        .usec(usec),
        .us_tick(us_tick),
        .ms_tick(ms_tick),
        .s_tick(s_tick),
        .sec_wrap(sec_wrap),
`ifdef TIMEBASE_ALARM_EN
        .alarm_arm(alarm_arm),
        .alarm_sec(alarm_sec),
        .alarm_msec(alarm_msec),
        .alarm_clr(alarm_clr),
        .alarm_irq(alarm_irq),
`endif
        .snap(sif)
    );

    always #5 clk_200mhz = ~clk_200mhz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_200mhz);
        #1;
    endtask

    task automatic do_load(input int s, input int m, input int u);
        load      = 1'b1;
        load_sec  = SEC_W'(s);
        load_msec = SUB_W'(m);
        load_usec = SUB_W'(u);
        step();
        load = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int s, input int m, input int u);
        chk({tag, "_sec"},  64'(sec),  64'(s));
        chk({tag, "_msec"}, 64'(msec), 64'(m));
        chk({tag, "_usec"}, 64'(usec), 64'(u));
    endtask

    task automatic chk_snap(input string tag);
        exp_s = exp_q[0];
        chk({tag, "_valid"}, 64'(sif.snap_valid), 64'd1);
        chk({tag, "_data"}, 64'({sif.snap_sec, sif.snap_msec, sif.snap_usec}), 64'(exp_s));
    endtask

    initial begin
        int us_cnt;
        int ms_cnt;
        int tick_cnt;
        int budget;
        reset = 1'b1; en = 1'b0; load = 1'b0;
        load_sec = '0; load_msec = '0; load_usec = '0;
        sif.snap_req = 1'b0; sif.snap_ready = 1'b0;
`ifdef TIMEBASE_ALARM_EN
        alarm_arm = 1'b0; alarm_sec = '0; alarm_msec = '0; alarm_clr = 1'b0;
`endif
        step();
        step();
        chk_time("reset", 0, 0, 0);
        chk("reset_ticks", 64'({us_tick, ms_tick, s_tick, sec_wrap}), 64'd0);
        chk("reset_snap", 64'({sif.snap_valid, sif.snap_drop, sif.snap_sec, sif.snap_msec, sif.snap_usec}), 64'd0);

        // 1: 4000 cycles -> 1 ms, 1000 us ticks, one ms tick
        reset = 1'b0; en = 1'b1;
        us_cnt = 0; ms_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            us_cnt += int'(us_tick);
            ms_cnt += int'(ms_tick);
        end
        chk_time("t1", 0, 1, 0);
        chk("t1_us_ticks", 64'(us_cnt), 64'd1000);
        chk("t1_ms_ticks", 64'(ms_cnt), 64'd1);

        // 2: second rollover, all ticks coincide
        en = 1'b0;
        do_load(5, 999, 999);
        chk_time("t2_load", 5, 999, 999);
        chk("t2_load_ticks", 64'({us_tick, ms_tick, s_tick}), 64'd0);
        en = 1'b1;
        step(); step(); step();
        chk_time("t2_hold", 5, 999, 999);
        step();
        chk_time("t2_roll", 6, 0, 0);
        chk("t2_ticks", 64'({us_tick, ms_tick, s_tick, sec_wrap}), 64'b1110);

        // 3: seconds wrap and load saturation
        en = 1'b0;
        do_load(15, 1000, 1023);
        chk_time("t3_sat", 15, 999, 999);
        en = 1'b1;
        step(); step(); step(); step();
        chk_time("t3_wrap", 0, 0, 0);
        chk("t3_wrap_ticks", 64'({s_tick, sec_wrap}), 64'b11);
        step();
        chk("t3_wrap_pulse", 64'(sec_wrap), 64'd0);

        // 4: snapshot hold, drop, release
        en = 1'b0;
        do_load(3, 123, 456);
        sif.snap_req = 1'b1;
        exp_q.push_back('{s: 4'd3, m: 10'd123, u: 10'd456});
        step();
        sif.snap_req = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk_snap("t4_hold");
        chk_time("t4_time_moves", 3, 123, 458);
        chk("t4_no_drop", 64'(sif.snap_drop), 64'd0);
        sif.snap_req = 1'b1;
        step();
        sif.snap_req = 1'b0;
        chk("t4_drop", 64'(sif.snap_drop), 64'd1);
        chk_snap("t4_after_drop");
        step();
        chk("t4_drop_pulse", 64'(sif.snap_drop), 64'd0);
        chk_snap("t4_pop");
        void'(exp_q.pop_front());
        sif.snap_ready = 1'b1;
        step();
        sif.snap_ready = 1'b0;
        chk("t4_released", 64'(sif.snap_valid), 64'd0);

        // 4b: request coincident with the handshake keeps valid with new data
        en = 1'b0;
        do_load(7, 1, 2);
        sif.snap_req = 1'b1;
        exp_q.push_back('{s: 4'd7, m: 10'd1, u: 10'd2});
        step();
        sif.snap_req = 1'b0;
        do_load(8, 3, 4);
        chk_snap("t4b_first");
        void'(exp_q.pop_front());
        sif.snap_req = 1'b1; sif.snap_ready = 1'b1;
        exp_q.push_back('{s: 4'd8, m: 10'd3, u: 10'd4});
        step();
        sif.snap_req = 1'b0; sif.snap_ready = 1'b0;
        chk("t4b_no_drop", 64'(sif.snap_drop), 64'd0);
        chk_snap("t4b_second");
        void'(exp_q.pop_front());
        sif.snap_ready = 1'b1;
        step();
        sif.snap_ready = 1'b0;
        chk("t4b_released", 64'(sif.snap_valid), 64'd0);
        chk("t4b_queue_empty", 64'(exp_q.size()), 64'd0);

        // 5: enable freeze mid-prescale, resume from held prescaler
        do_load(2, 10, 20);
        en = 1'b1;
        step(); step();
        en = 1'b0;
        tick_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            tick_cnt += int'(us_tick) + int'(ms_tick) + int'(s_tick) + int'(sec_wrap);
        end
        chk_time("t5_frozen", 2, 10, 20);
        chk("t5_no_ticks", 64'(tick_cnt), 64'd0);
        en = 1'b1;
        step();
        chk_time("t5_resume_wait", 2, 10, 20);
        step();
        chk_time("t5_resume", 2, 10, 21);
        chk("t5_resume_tick", 64'(us_tick), 64'd1);

        // 5b: asynchronous reset mid-run with a snapshot pending
        sif.snap_req = 1'b1;
        step();
        sif.snap_req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk_time("t5_async_reset", 0, 0, 0);
        chk("t5_async_snap", 64'({sif.snap_valid, sif.snap_sec, sif.snap_msec, sif.snap_usec}), 64'd0);
        step();
        reset = 1'b0;
        en = 1'b0;

`ifdef TIMEBASE_ALARM_EN
        // 6: alarm at {0,2}, sticky until clear, no second fire
        alarm_arm = 1'b1; alarm_sec = '0; alarm_msec = 10'd2;
        step();
        alarm_arm = 1'b0;
        en = 1'b1;
        budget = 0;
        while (alarm_irq !== 1'b1 && budget < 9000) begin
            step();
            budget++;
        end
        chk("t6_fired_in_budget", 64'(budget < 9000), 64'd1);
        chk_time("t6_fire_time", 0, 2, 0);
        for (int i = 0; i < 50; i++) step();
        chk("t6_sticky", 64'(alarm_irq), 64'd1);
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        chk("t6_cleared", 64'(alarm_irq), 64'd0);
        en = 1'b0;
        do_load(0, 1, 999);
        en = 1'b1;
        step(); step(); step(); step();
        chk_time("t6_pass_again", 0, 2, 0);
        chk("t6_no_refire", 64'(alarm_irq), 64'd0);
        en = 1'b0;
        alarm_arm = 1'b1; alarm_msec = 10'd5;
        step();
        alarm_arm = 1'b0;
        do_load(0, 5, 0);
        chk("t6_load_no_fire", 64'(alarm_irq), 64'd0);
        alarm_arm = 1'b1; alarm_msec = 10'd6;
        step();
        alarm_arm = 1'b0;
        do_load(0, 5, 999);
        en = 1'b1;
        step(); step(); step();
        alarm_clr = 1'b1;
        step();
        alarm_clr = 1'b0;
        chk_time("t6_clr_time", 0, 6, 0);
        chk("t6_clr_wins", 64'(alarm_irq), 64'd0);
        step();
        chk("t6_clr_wins_after", 64'(alarm_irq), 64'd0);
        en = 1'b0;
`else
        budget = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
